// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - N-channel arbitrating mux with a registered valid/ready output stage
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic             w_has_cand;
  logic [SELW-1:0]  w_cand;
  logic [WIDTH-1:0] w_cand_data;

  assign w_load_en = !r_out_valid || out_ready;

  // sel values at or beyond N match no channel, so they yield no candidate
  always_comb begin
    int idx;
    w_has_cand = 1'b0;
    w_cand     = '0;
    idx        = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          w_has_cand = 1'b1;
          w_cand     = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!w_has_cand && in_valid[idx]) begin
          w_has_cand = 1'b1;
          w_cand     = idx[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand == SELW'(i)) w_cand_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (!reset && w_load_en && w_has_cand && w_cand == SELW'(i)) in_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_has_cand) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cand_data;
        r_out_src   <= w_cand;
        r_ptr       <= (w_cand == LAST) ? '0 : w_cand + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data bits per channel.
REQ-002 Parameter N, default 4, range 2..16, SHALL set the number of input channels.
REQ-003 Parameter MODE, default 0, SHALL set source choice: 0 = external select, 1 = round-robin.
REQ-004 Parameter SELW, default 2, SHALL equal ceil(log2(N)) and set the width of sel, out_src and the pointer.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 in_data  input  N*WIDTH  SHALL carry channel i data in bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-008 in_valid  input  N  SHALL flag, per channel, that its data is offered.
REQ-009 in_ready  output  N  SHALL flag, per channel, that its data is taken this cycle.
REQ-010 sel  input  SELW  SHALL give the channel index used in MODE 0; it is ignored in MODE 1.
REQ-011 out_data  output  WIDTH  SHALL be the registered selected data.
REQ-012 out_valid  output  1  SHALL flag that out_data/out_src hold a word.
REQ-013 out_ready  input  1  SHALL flag that the consumer accepts the output word.
REQ-014 out_src  output  SELW  SHALL be the index of the channel that supplied out_data.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready); it SHALL be the only condition under which the output register may change.
REQ-016 MODE 0 candidate: channel sel, only if sel < N and in_valid[sel] = 1; otherwise no candidate.
REQ-017 MODE 1 candidate: first i with in_valid[i] = 1, searched ptr, ptr+1, ..., N-1, 0, ..., ptr-1; if none valid, no candidate.
REQ-018 in_ready[i] SHALL be 1 only when load_en = 1 and i is the candidate; at most one in_ready bit SHALL be high per cycle.
REQ-019 in_ready is combinational from in_valid, sel, out_valid, out_ready and ptr; no combinational path from in_data.
REQ-020 Transfer on channel c (in_valid[c] and in_ready[c]): next cycle out_data = in_data channel c, out_src = c, out_valid = 1 (latency 1 cycle).
REQ-021 load_en = 1 with no candidate: out_valid SHALL go 0; out_data and out_src SHALL hold their previous values.
REQ-022 load_en = 0 (out_valid = 1, out_ready = 0): out_data, out_src, out_valid SHALL hold; all in_ready = 0.
REQ-023 Simultaneous output accept and new transfer SHALL sustain one word per cycle with no bubble.
REQ-024 ptr SHALL update only on a transfer, to (c+1) wrapping N-1 -> 0; it is also kept, unused, in MODE 0.
REQ-025 Data SHALL pass unmodified; no word SHALL be duplicated or dropped.

Reset
REQ-026 While reset = 1: out_valid = 0, out_data = 0, out_src = 0, ptr = 0, all in_ready = 0, asynchronously.
REQ-027 Reset asserted mid-stream SHALL discard the held word; first transfer after release SHALL follow REQ-017 from ptr = 0.

Verification
REQ-028 MODE 0, N=4, sel=2, in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xDEADBEEF, out_src=2, out_valid=1.
REQ-029 MODE 0, sel=1, in_valid=4'b1101 -> in_ready=0; out_valid drops to 0 next cycle; out_data holds.
REQ-030 MODE 1, all 4 valid, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1 (wrap), one word per cycle.
REQ-031 MODE 1, out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 throughout, out_data/out_src stable; on out_ready=1, next channel granted same cycle.
REQ-032 Reset pulse while out_valid=1, ptr=3 -> out_valid=0, out_data=0, out_src=0 immediately; next grant with all valid is channel 0.
REQ-033 N=3, WIDTH=8, MODE 0, sel=3 with in_valid=3'b111 -> no in_ready high, out_valid=0.
